nukv_privacy_request_framer: RTL and testbench

//  Upstream transmitter for the privacy pipeline. Splits one framed request stream (header beat + payload beats) into
//  the pred channel (one header word per request) and the value channel (all beats, re-delimited by header length).

---
 rtl/nukv_privacy_request_framer_pkg.sv | 20 ++
 rtl/nukv_privacy_request_framer_if.sv | 26 ++
 rtl/nukv_axis_out_reg.sv | 33 +++
 rtl/nukv_privacy_request_framer.sv | 146 ++++++++++++++
 tb/tb_nukv_privacy_request_framer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nukv_privacy_request_framer_pkg.sv
// rtl/nukv_privacy_request_framer_pkg.sv - shared opcodes, FSM states and beat-count helper
package nukv_privacy_request_framer_pkg;

  localparam logic [7:0] OP_BYPASS = 8'h00;
  localparam logic [7:0] OP_ROTATE = 8'h01;
  localparam logic [7:0] OP_MATRIX = 8'hFE;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  // A zero-length value still occupies its header beat.
  function automatic int unsigned beats_of(input int unsigned len, input int unsigned bpb);
    if (len == 0) return 1;
    return (len + bpb - 1) / bpb;
  endfunction

endpackage

// File: rtl/nukv_privacy_request_framer_if.sv
// rtl/nukv_privacy_request_framer_if.sv - command, pred and value streams of the request framer
interface nukv_privacy_request_framer_if #(
  parameter int MEMORY_WIDTH = 512
);
  logic [MEMORY_WIDTH-1:0] cmd_data;
  logic                    cmd_valid;
  logic                    cmd_last;
  logic                    cmd_ready;
  logic [MEMORY_WIDTH-1:0] pred_data;
  logic                    pred_valid;
  logic                    pred_ready;
  logic [MEMORY_WIDTH-1:0] value_data;
  logic                    value_valid;
  logic                    value_last;
  logic                    value_ready;

  modport master (
    output cmd_data, cmd_valid, cmd_last, pred_ready, value_ready,
    input  cmd_ready, pred_data, pred_valid, value_data, value_valid, value_last
  );

  modport slave (
    input  cmd_data, cmd_valid, cmd_last, pred_ready, value_ready,
    output cmd_ready, pred_data, pred_valid, value_data, value_valid, value_last
  );
endinterface

// File: rtl/nukv_axis_out_reg.sv
// rtl/nukv_axis_out_reg.sv - single-entry registered stream slice; callers pack last into the data word
module nukv_axis_out_reg #(
  parameter int WIDTH = 513
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_loadable,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Reloading while the consumer takes the current word keeps full rate.
  assign o_loadable = !r_valid || i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/nukv_privacy_request_framer.sv
// rtl/nukv_privacy_request_framer.sv - splits framed requests into pred (header) and value (length-delimited) streams
module nukv_privacy_request_framer
  import nukv_privacy_request_framer_pkg::*;
#(
  parameter int MEMORY_WIDTH        = 512,
  parameter int COL_COUNT           = 3,
  parameter int COL_WIDTH           = 64,
  parameter int VALUE_SIZE_BYTES_NO = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  nukv_privacy_request_framer_if.slave bus,
  output logic [31:0] o_stat_requests,
  output logic [15:0] o_stat_err_short,
  output logic [15:0] o_stat_err_long,
  output logic [15:0] o_stat_err_matrix
);
  localparam int          BPB          = MEMORY_WIDTH / 8;
  localparam int          LW           = 8 * VALUE_SIZE_BYTES_NO;
  localparam int          RW           = LW + 1;
  localparam int unsigned MATRIX_BYTES = COL_COUNT * COL_COUNT * COL_WIDTH / 8;

  state_t          r_state, w_state_next;
  logic [RW-1:0]   r_remaining, w_remaining_next;
  logic [LW-1:0]   w_len;
  logic [7:0]      w_op;
  logic [RW-1:0]   w_nbeats;
  logic            w_val_loadable, w_pred_loadable;
  logic            w_cmd_ready, w_val_load, w_val_last, w_pred_load;
  logic            w_inc_req, w_inc_short, w_inc_long, w_inc_matrix;
  logic [31:0]     r_stat_requests;
  logic [15:0]     r_stat_err_short, r_stat_err_long, r_stat_err_matrix;

  assign w_len    = bus.cmd_data[LW-1:0];
  assign w_op     = bus.cmd_data[LW +: 8];
  assign w_nbeats = RW'(beats_of(32'(w_len), BPB));

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_cmd_ready      = 1'b0;
    w_val_load       = 1'b0;
    w_val_last       = 1'b0;
    w_pred_load      = 1'b0;
    w_inc_req        = 1'b0;
    w_inc_short      = 1'b0;
    w_inc_long       = 1'b0;
    w_inc_matrix     = 1'b0;
    case (r_state)
      HDR: begin
        w_cmd_ready = w_val_loadable && w_pred_loadable;
        if (bus.cmd_valid && w_cmd_ready) begin
          w_val_load       = 1'b1;
          w_pred_load      = 1'b1;
          w_inc_req        = 1'b1;
          w_inc_matrix     = (w_op == OP_MATRIX) && (32'(w_len) != MATRIX_BYTES);
          w_remaining_next = w_nbeats - RW'(1);
          if (w_nbeats == RW'(1)) begin
            w_val_last = 1'b1;
            if (!bus.cmd_last) begin
              w_inc_long   = 1'b1;
              w_state_next = DROP;
            end
          end else if (bus.cmd_last) begin
            w_val_last  = 1'b1;
            w_inc_short = 1'b1;
          end else begin
            w_state_next = BODY;
          end
        end
      end
      BODY: begin
        w_cmd_ready = w_val_loadable;
        if (bus.cmd_valid && w_cmd_ready) begin
          w_val_load       = 1'b1;
          w_remaining_next = r_remaining - RW'(1);
          if (r_remaining == RW'(1)) begin
            w_val_last = 1'b1;
            if (bus.cmd_last) begin
              w_state_next = HDR;
            end else begin
              w_inc_long   = 1'b1;
              w_state_next = DROP;
            end
          end else if (bus.cmd_last) begin
            w_val_last   = 1'b1;
            w_inc_short  = 1'b1;
            w_state_next = HDR;
          end
        end
      end
      DROP: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid && bus.cmd_last) w_state_next = HDR;
      end
      default: w_state_next = HDR;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state           <= HDR;
      r_remaining       <= '0;
      r_stat_requests   <= '0;
      r_stat_err_short  <= '0;
      r_stat_err_long   <= '0;
      r_stat_err_matrix <= '0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      // Counters stick at all-ones rather than wrapping.
      if (w_inc_req && r_stat_requests != '1)      r_stat_requests   <= r_stat_requests + 32'd1;
      if (w_inc_short && r_stat_err_short != '1)   r_stat_err_short  <= r_stat_err_short + 16'd1;
      if (w_inc_long && r_stat_err_long != '1)     r_stat_err_long   <= r_stat_err_long + 16'd1;
      if (w_inc_matrix && r_stat_err_matrix != '1) r_stat_err_matrix <= r_stat_err_matrix + 16'd1;
    end
  end

  assign bus.cmd_ready     = w_cmd_ready;
  assign o_stat_requests   = r_stat_requests;
  assign o_stat_err_short  = r_stat_err_short;
  assign o_stat_err_long   = r_stat_err_long;
  assign o_stat_err_matrix = r_stat_err_matrix;

  nukv_axis_out_reg #(.WIDTH(MEMORY_WIDTH + 1)) u_value_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_val_load),
    .i_data     ({w_val_last, bus.cmd_data}),
    .i_ready    (bus.value_ready),
    .o_loadable (w_val_loadable),
    .o_valid    (bus.value_valid),
    .o_data     ({bus.value_last, bus.value_data})
  );

  nukv_axis_out_reg #(.WIDTH(MEMORY_WIDTH)) u_pred_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_pred_load),
    .i_data     (bus.cmd_data),
    .i_ready    (bus.pred_ready),
    .o_loadable (w_pred_loadable),
    .o_valid    (bus.pred_valid),
    .o_data     (bus.pred_data)
  );
endmodule

// File: tb/tb_nukv_privacy_request_framer.sv
// tb/tb_nukv_privacy_request_framer.sv - randomized bench with request-level reference model for the framer
module tb_nukv_privacy_request_framer;
  typedef logic [511:0] word_t;
  typedef struct {
    word_t d;
    bit    l;
  } vbeat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] stat_requests;
  logic [15:0] stat_err_short, stat_err_long, stat_err_matrix;

  nukv_privacy_request_framer_if #(.MEMORY_WIDTH(512)) bus ();

  nukv_privacy_request_framer dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .bus               (bus.slave),
    .o_stat_requests   (stat_requests),
    .o_stat_err_short  (stat_err_short),
    .o_stat_err_long   (stat_err_long),
    .o_stat_err_matrix (stat_err_matrix)
  );

  always #5 clk = ~clk;

  word_t  stim_q[$];
  bit     stim_last_q[$];
  word_t  exp_pred_q[$];
  vbeat_t exp_val_q[$];
  int     m_req, m_short, m_long, m_matrix;
  int     n_pred, n_vlast, n_vbeat;
  int     checks, fails;
  int     rmode;
  bit     gaps;
  bit     acc_flag;
  word_t  last_pred;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Request-level model: min(sent, needed) beats go out, the last of them flagged.
  task automatic add_req(input int len, input logic [7:0] op, input int k);
    word_t hdr;
    word_t w;
    int    nb, em;
    hdr        = rand_word();
    hdr[15:0]  = len[15:0];
    hdr[23:16] = op;
    nb = (len == 0) ? 1 : (len + 63) / 64;
    em = (k < nb) ? k : nb;
    exp_pred_q.push_back(hdr);
    m_req++;
    if (op == 8'hFE && len != 72) m_matrix++;
    if (k < nb) m_short++;
    if (k > nb) m_long++;
    for (int i = 0; i < k; i++) begin
      w = (i == 0) ? hdr : rand_word();
      stim_q.push_back(w);
      stim_last_q.push_back(i == k - 1);
      if (i < em) exp_val_q.push_back('{d: w, l: (i == em - 1)});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pred_valid && bus.pred_ready) begin
        checks++;
        if (exp_pred_q.size() == 0) begin
          fails++;
          $display("FAIL pred_unexpected: got %h expected none", bus.pred_data);
        end else begin
          if (bus.pred_data !== exp_pred_q[0]) begin
            fails++;
            $display("FAIL pred_data: got %h expected %h", bus.pred_data, exp_pred_q[0]);
          end
          void'(exp_pred_q.pop_front());
        end
        last_pred = bus.pred_data;
        n_pred++;
      end
      if (bus.value_valid && bus.value_ready) begin
        checks++;
        if (exp_val_q.size() == 0) begin
          fails++;
          $display("FAIL value_unexpected: got %h expected none", bus.value_data);
        end else begin
          if (bus.value_data !== exp_val_q[0].d || bus.value_last !== exp_val_q[0].l) begin
            fails++;
            $display("FAIL value_beat: got last=%0d %h expected last=%0d %h",
                     bus.value_last, bus.value_data, exp_val_q[0].l, exp_val_q[0].d);
          end
          void'(exp_val_q.pop_front());
        end
        n_vbeat++;
        if (bus.value_last) n_vlast++;
      end
      if (bus.cmd_valid && bus.cmd_ready && stim_q.size() != 0) begin
        acc_flag = 1'b1;
        void'(stim_q.pop_front());
        void'(stim_last_q.pop_front());
      end
    end
  end

  task automatic cycle();
    bit held;
    @(posedge clk);
    #1;
    bus.pred_ready  = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom % 4 != 0);
    bus.value_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom % 4 != 0);
    held     = bus.cmd_valid && !acc_flag;
    acc_flag = 1'b0;
    if (stim_q.size() == 0) begin
      bus.cmd_valid = 1'b0;
    end else begin
      if (!held) bus.cmd_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
      bus.cmd_data = stim_q[0];
      bus.cmd_last = stim_last_q[0];
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || exp_pred_q.size() != 0 || exp_val_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, budget);
    end
    repeat (3) cycle();
    chk({name, "_pred_idle"}, bus.pred_valid, 0);
    chk({name, "_value_idle"}, bus.value_valid, 0);
  endtask

  task automatic chk_stats(input string name);
    chk({name, "_requests"}, stat_requests, m_req);
    chk({name, "_short"}, stat_err_short, m_short);
    chk({name, "_long"}, stat_err_long, m_long);
    chk({name, "_matrix"}, stat_err_matrix, m_matrix);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, nb, k, r;
    logic [7:0] op;
    bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0; bus.cmd_data = '0;
    bus.pred_ready = 1'b1; bus.value_ready = 1'b1;
    rmode = 0; gaps = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pred_valid", bus.pred_valid, 0);
    chk("rst_value_valid", bus.value_valid, 0);
    chk("rst_value_last", bus.value_last, 0);
    chk("rst_requests", stat_requests, 0);
    rst = 1'b0;

    add_req(64, 8'h01, 1);
    drain("t1", 100);
    chk("t1_pred_op", last_pred[23:16], 8'h01);
    chk("t1_npred", n_pred, 1);
    chk("t1_nvlast", n_vlast, 1);
    chk("t1_requests", stat_requests, 1);
    chk("t1_err_short", stat_err_short, 0);

    add_req(200, 8'h00, 4);
    drain("t2", 100);
    chk("t2_nvbeat", n_vbeat, 5);
    chk("t2_npred", n_pred, 2);

    add_req(200, 8'h00, 2);
    add_req(64, 8'h01, 1);
    drain("t3", 100);
    chk("t3_nvbeat", n_vbeat, 8);
    chk("t3_err_short", stat_err_short, 1);

    add_req(64, 8'h01, 3);
    add_req(64, 8'h00, 1);
    drain("t4", 100);
    chk("t4_nvbeat", n_vbeat, 10);
    chk("t4_err_long", stat_err_long, 1);
    chk("t4_requests", stat_requests, 6);

    add_req(72, 8'hFE, 2);
    chk("t5_matrix_first", m_matrix, 0);
    add_req(64, 8'hFE, 1);
    drain("t5", 100);
    chk("t5_err_matrix", stat_err_matrix, 1);
    chk("t5_nvbeat", n_vbeat, 13);
    chk_stats("t5");

    // Leave a half-delivered request stalled in the output regs, then reset.
    rmode = 2;
    stim_q.push_back(rand_word());
    stim_q[0][15:0] = 16'd200;
    stim_last_q.push_back(1'b0);
    stim_q.push_back(rand_word());
    stim_last_q.push_back(1'b0);
    repeat (4) cycle();
    chk("mid_pred_held", bus.pred_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    stim_q.delete(); stim_last_q.delete();
    exp_pred_q.delete(); exp_val_q.delete();
    acc_flag = 1'b0;
    m_req = 0; m_short = 0; m_long = 0; m_matrix = 0;
    n_pred = 0; n_vlast = 0; n_vbeat = 0;
    #1;
    chk("mid_rst_pred_valid", bus.pred_valid, 0);
    chk("mid_rst_value_valid", bus.value_valid, 0);
    chk("mid_rst_requests", stat_requests, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rmode = 0;
    add_req(128, 8'h01, 2);
    drain("post_rst", 100);
    chk_stats("post_rst");

    rmode = 1; gaps = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r  = $urandom % 4;
      op = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : (r == 2) ? 8'hFE : 8'($urandom);
      if ($urandom % 8 == 0) begin
        r   = $urandom % 5;
        len = (r == 0) ? 0 : (r == 1) ? 64 : (r == 2) ? 65 : (r == 3) ? 72 : 128;
      end else begin
        len = $urandom_range(0, 320);
      end
      nb = (len == 0) ? 1 : (len + 63) / 64;
      r  = $urandom % 6;
      k  = (r == 0) ? $urandom_range(1, nb) : (r == 1) ? nb + $urandom_range(1, 2) : nb;
      add_req(len, op, k);
    end
    drain("random", 60000);
    chk_stats("random");
    chk("random_pred_eq_vlast", n_pred, n_vlast);
    chk("random_pred_eq_req", n_pred, m_req);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
